// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster generator driven from the 50 MHz clock.
// A Clk/2 pixel enable advances DrawX/DrawY; sync/blank decodes are taken
// from the next counter value and registered so they line up with the
// coordinates they describe. A frame_start pulse and a frame counter mark
// each wrap back to (0,0).
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_clk,
  output logic       hs,
  output logic       vs,
  output logic       blank_n,
  output logic       sync_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       frame_wrap;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       blank_n_nxt;

  // Next raster position: advance only on the pixel_clk-high phase, so each
  // coordinate is held for two Clk cycles. frame_wrap flags the (last,last)->(0,0) step.
  always_comb begin
    x_nxt      = DrawX;
    y_nxt      = DrawY;
    frame_wrap = 1'b0;
    if (pixel_clk) begin
      if (DrawX == H_LAST) begin
        x_nxt = 10'd0;
        if (DrawY == V_LAST) begin
          y_nxt      = 10'd0;
          frame_wrap = 1'b1;
        end else begin
          y_nxt = DrawY + 10'd1;
        end
      end else begin
        x_nxt = DrawX + 10'd1;
      end
    end
  end

  // Decodes of the next position; registering them gives zero latency
  // relative to DrawX/DrawY.
  always_comb begin
    hs_nxt      = ~((x_nxt >= HS_BEG) && (x_nxt < HS_END));
    vs_nxt      = ~((y_nxt >= VS_BEG) && (y_nxt < VS_END));
    blank_n_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  end

  // Raster state, decoded outputs and frame bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_clk   <= 1'b0;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      pixel_clk   <= ~pixel_clk;
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      blank_n     <= blank_n_nxt;
      frame_start <= frame_wrap;
      if (frame_wrap) frame_count <= frame_count + 8'd1;
    end
  end

  // Composite sync is not used by the DAC.
  assign sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance checks reset release and
// line timing; a shrunken-raster instance makes whole frames and a 256-frame
// counter wrap affordable. A reference raster model per instance pushes the
// expected outputs for every Clk edge into a queue that is popped after the edge.
module tb_vga_timing_gen;

  localparam int SH_VIS = 4, SH_FP = 1, SH_SYNC = 2, SH_BP = 1;
  localparam int SV_VIS = 3, SV_FP = 1, SV_SYNC = 2, SV_BP = 1;
  localparam int S_HT = SH_VIS + SH_FP + SH_SYNC + SH_BP;
  localparam int S_VT = SV_VIS + SV_FP + SV_SYNC + SV_BP;
  localparam int S_FRAME = 2 * S_HT * S_VT;

  logic       Clk = 1'b0;
  logic       rst_d = 1'b1;
  logic       rst_s = 1'b1;

  logic       d_pc, d_hs, d_vs, d_bn, d_sn, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic       s_pc, s_hs, s_vs, s_bn, s_sn, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  always #5 Clk = ~Clk;

  vga_timing_gen dut_d (
    .Clk(Clk), .Reset(rst_d), .pixel_clk(d_pc), .hs(d_hs), .vs(d_vs),
    .blank_n(d_bn), .sync_n(d_sn), .DrawX(d_x), .DrawY(d_y),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) dut_s (
    .Clk(Clk), .Reset(rst_s), .pixel_clk(s_pc), .hs(s_hs), .vs(s_vs),
    .blank_n(s_bn), .sync_n(s_sn), .DrawX(s_x), .DrawY(s_y),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  typedef struct packed {
    logic       pc;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       sn;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] fc;
  } obs_t;

  obs_t q_d[$];
  obs_t q_s[$];
  obs_t last_d, last_s;

  int checks = 0;
  int errors = 0;

  // Reference raster state and geometry, index 0 = full size, 1 = small.
  int m_pc[2], m_x[2], m_y[2], m_fc[2], m_fs[2];
  int p_hv[2], p_hsb[2], p_hse[2], p_ht[2];
  int p_vv[2], p_vsb[2], p_vse[2], p_vt[2];

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%0b hs=%0b vs=%0b bn=%0b sn=%0b fs=%0b x=%0d y=%0d fc=%0d",
                     o.pc, o.hs, o.vs, o.bn, o.sn, o.fs, o.x, o.y, o.fc);
  endfunction

  // Advance reference k by one Clk edge and return the outputs expected after it.
  function automatic obs_t model_next(input int k, input bit rst);
    obs_t o;
    int   adv;
    if (rst) begin
      m_pc[k] = 0; m_x[k] = 0; m_y[k] = 0; m_fc[k] = 0; m_fs[k] = 0;
    end else begin
      adv     = m_pc[k];
      m_pc[k] = 1 - m_pc[k];
      m_fs[k] = 0;
      if (adv == 1) begin
        if (m_x[k] == p_ht[k] - 1) begin
          m_x[k] = 0;
          if (m_y[k] == p_vt[k] - 1) begin
            m_y[k]  = 0;
            m_fs[k] = 1;
            m_fc[k] = (m_fc[k] + 1) % 256;
          end else begin
            m_y[k] = m_y[k] + 1;
          end
        end else begin
          m_x[k] = m_x[k] + 1;
        end
      end
    end
    o.pc = (m_pc[k] != 0);
    o.sn = 1'b0;
    o.fs = (m_fs[k] != 0);
    o.x  = 10'(m_x[k]);
    o.y  = 10'(m_y[k]);
    o.fc = 8'(m_fc[k]);
    if (rst) begin
      o.hs = 1'b1; o.vs = 1'b1; o.bn = 1'b0;
    end else begin
      o.hs = !(m_x[k] >= p_hsb[k] && m_x[k] < p_hse[k]);
      o.vs = !(m_y[k] >= p_vsb[k] && m_y[k] < p_vse[k]);
      o.bn = (m_x[k] < p_hv[k]) && (m_y[k] < p_vv[k]);
    end
    return o;
  endfunction

  // One Clk edge: drive resets, push expectations, sample after the edge, score.
  task automatic step(input bit rd, input bit rs);
    obs_t e;
    rst_d = rd;
    rst_s = rs;
    q_d.push_back(model_next(0, rd));
    q_s.push_back(model_next(1, rs));
    @(posedge Clk);
    #1;
    last_d = '{d_pc, d_hs, d_vs, d_bn, d_sn, d_fs, d_x, d_y, d_fc};
    last_s = '{s_pc, s_hs, s_vs, s_bn, s_sn, s_fs, s_x, s_y, s_fc};
    e = q_d.pop_front();
    checks++;
    if (last_d !== e) begin
      errors++;
      if (errors < 30) $display("FAIL sb_full: got %s want %s", fmt(last_d), fmt(e));
    end
    e = q_s.pop_front();
    checks++;
    if (last_s !== e) begin
      errors++;
      if (errors < 30) $display("FAIL sb_small: got %s want %s", fmt(last_s), fmt(e));
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      step(1'b1, 1'b1);
      checks++;
      if (d_x !== 10'd0 || d_y !== 10'd0 || d_hs !== 1'b1 || d_vs !== 1'b1 ||
          d_bn !== 1'b0 || d_pc !== 1'b0 || d_fs !== 1'b0 || d_fc !== 8'd0) begin
        errors++;
        $display("FAIL reset_values: got %s want all-reset", fmt(last_d));
      end
    end
    step(1'b0, 1'b0);
    checks++;
    if (d_pc !== 1'b1 || d_bn !== 1'b1 || d_x !== 10'd0 || d_y !== 10'd0) begin
      errors++;
      $display("FAIL release_edge1: got pc=%0b bn=%0b x=%0d y=%0d want pc=1 bn=1 x=0 y=0",
               d_pc, d_bn, d_x, d_y);
    end
    step(1'b0, 1'b0);
    checks++;
    if (d_pc !== 1'b0 || d_x !== 10'd1 || d_fs !== 1'b0) begin
      errors++;
      $display("FAIL release_edge2: got pc=%0b x=%0d fs=%0b want pc=0 x=1 fs=0", d_pc, d_x, d_fs);
    end
  endtask

  task automatic test_line();
    int   hs_lo = 0, bn_lo = 0, hmin = 1023, hmax = 0, bmin = 1023, bmax = 0, wraps = 0;
    obs_t prev = last_d;
    repeat (1600) begin
      step(1'b0, 1'b0);
      if (!last_d.hs) begin
        hs_lo++;
        if (int'(last_d.x) < hmin) hmin = int'(last_d.x);
        if (int'(last_d.x) > hmax) hmax = int'(last_d.x);
      end
      if (!last_d.bn) begin
        bn_lo++;
        if (int'(last_d.x) < bmin) bmin = int'(last_d.x);
        if (int'(last_d.x) > bmax) bmax = int'(last_d.x);
      end
      if (prev.x == 10'd799 && last_d.x == 10'd0) begin
        wraps++;
        checks++;
        if (last_d.y !== prev.y + 10'd1) begin
          errors++;
          $display("FAIL line_y_step: got y=%0d want %0d", last_d.y, prev.y + 10'd1);
        end
      end
      prev = last_d;
    end
    checks++;
    if (hs_lo != 192 || hmin != 656 || hmax != 751) begin
      errors++;
      $display("FAIL line_hs: got %0d clk x=%0d..%0d want 192 clk x=656..751", hs_lo, hmin, hmax);
    end
    checks++;
    if (bn_lo != 320 || bmin != 640 || bmax != 799) begin
      errors++;
      $display("FAIL line_blank: got %0d clk x=%0d..%0d want 320 clk x=640..799", bn_lo, bmin, bmax);
    end
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL line_wrap_count: got %0d want 1", wraps);
    end
  endtask

  // Wait (bounded) for a small-instance frame_start; report a timeout as a failure.
  task automatic wait_small_fs(input string tag);
    int n = 0;
    while (!last_s.fs && n < 2 * S_FRAME + 8) begin
      step(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (!last_s.fs) begin
      errors++;
      $display("FAIL %s_timeout: got no frame_start in %0d clk want one", tag, n);
    end
  endtask

  task automatic test_frame();
    int len = 0, vs_lo = 0, vmin = 1023, vmax = 0, bad_blank = 0;
    wait_small_fs("frame");
    do begin
      step(1'b0, 1'b0);
      len++;
      if (!last_s.vs) begin
        vs_lo++;
        if (int'(last_s.y) < vmin) vmin = int'(last_s.y);
        if (int'(last_s.y) > vmax) vmax = int'(last_s.y);
      end
      if (last_s.bn && int'(last_s.y) >= SV_VIS) bad_blank++;
    end while (!last_s.fs && len < 2 * S_FRAME);
    checks++;
    if (len != S_FRAME) begin
      errors++;
      $display("FAIL frame_len: got %0d clk want %0d", len, S_FRAME);
    end
    checks++;
    if (vs_lo != 2 * SV_SYNC * S_HT || vmin != SV_VIS + SV_FP || vmax != SV_VIS + SV_FP + SV_SYNC - 1) begin
      errors++;
      $display("FAIL frame_vs: got %0d clk y=%0d..%0d want %0d clk y=%0d..%0d", vs_lo, vmin, vmax,
               2 * SV_SYNC * S_HT, SV_VIS + SV_FP, SV_VIS + SV_FP + SV_SYNC - 1);
    end
    checks++;
    if (bad_blank != 0) begin
      errors++;
      $display("FAIL frame_blank: got %0d visible clk below line %0d want 0", bad_blank, SV_VIS);
    end
  endtask

  task automatic test_wrap256();
    int   frames = 0;
    logic [7:0] fc_before;
    step(1'b0, 1'b1);
    wait_small_fs("first_frame");
    checks++;
    if (last_s.fc !== 8'd1 || last_s.x !== 10'd0 || last_s.y !== 10'd0) begin
      errors++;
      $display("FAIL first_frame: got fc=%0d x=%0d y=%0d want fc=1 x=0 y=0", last_s.fc, last_s.x, last_s.y);
    end
    step(1'b0, 1'b0);
    checks++;
    if (last_s.fs !== 1'b0) begin
      errors++;
      $display("FAIL fs_width: got fs=%0b on second clk want 0", last_s.fs);
    end
    frames = 1;
    fc_before = last_s.fc;
    while (frames < 256) begin
      fc_before = last_s.fc;
      wait_small_fs("wrap256");
      if (!last_s.fs) break;
      frames++;
      if (frames < 256) step(1'b0, 1'b0);
    end
    checks++;
    if (last_s.fc !== 8'd0 || fc_before !== 8'd255) begin
      errors++;
      $display("FAIL fc_wrap: got %0d->%0d after %0d frames want 255->0", fc_before, last_s.fc, frames);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (!(last_s.hs === 1'b0 && last_s.vs === 1'b0 && last_s.fc != 8'd0) && n < 4 * S_FRAME) begin
      step(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (last_s.hs !== 1'b0 || last_s.vs !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_reach: got hs=%0b vs=%0b want 0 0", last_s.hs, last_s.vs);
    end
    step(1'b0, 1'b1);
    checks++;
    if (s_x !== 10'd0 || s_y !== 10'd0 || s_hs !== 1'b1 || s_vs !== 1'b1 ||
        s_bn !== 1'b0 || s_fc !== 8'd0 || s_fs !== 1'b0 || s_pc !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_small: got %s want all-reset", fmt(last_s));
    end
    n = 0;
    while (last_d.hs !== 1'b0 && n < 1700) begin
      step(1'b0, 1'b0);
      n++;
    end
    step(1'b1, 1'b0);
    checks++;
    if (d_x !== 10'd0 || d_y !== 10'd0 || d_hs !== 1'b1 || d_vs !== 1'b1 ||
        d_bn !== 1'b0 || d_fc !== 8'd0 || d_fs !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_full: got %s want all-reset", fmt(last_d));
    end
    repeat (2 * S_FRAME) step(1'b0, 1'b0);
  endtask

  initial begin
    p_hv[0] = 640; p_hsb[0] = 656; p_hse[0] = 752; p_ht[0] = 800;
    p_vv[0] = 480; p_vsb[0] = 490; p_vse[0] = 492; p_vt[0] = 525;
    p_hv[1] = SH_VIS; p_hsb[1] = SH_VIS + SH_FP; p_hse[1] = SH_VIS + SH_FP + SH_SYNC; p_ht[1] = S_HT;
    p_vv[1] = SV_VIS; p_vsb[1] = SV_VIS + SV_FP; p_vse[1] = SV_VIS + SV_FP + SV_SYNC; p_vt[1] = S_VT;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_x[k] = 0; m_y[k] = 0; m_fc[k] = 0; m_fs[k] = 0;
    end
    last_d = '0;
    last_s = '0;
    #2;
    test_reset();
    test_line();
    test_frame();
    test_wrap256();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
